fp_mult_scheduler: RTL and testbench

//  Round-robin scheduler sharing one Task6_Mult_top-style FP32 multiplier among
//  N_REQ requesters, e.g. the x*0.5, x*x, x/128 and x^2*cos products of the
//  y = 0.5x + x^2*cos((x-128)/128) datapath. It captures one operand pair,

---
 rtl/fp_mult_scheduler.sv | 122 ++++++++++++
 tb/tb_fp_mult_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_scheduler.sv
// Round-robin scheduler sharing one FP32 multiplier among N_REQ requesters.
// Captures the winner's operand pair, runs the multiplier enable/done
// handshake, returns the product to the owner and aborts with a qNaN if the
// multiplier never finishes within TIMEOUT cycles.
module fp_mult_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_dataa,
    input  logic [32*N_REQ-1:0] req_datab,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    resp_valid,
    output logic                resp_err,
    output logic [31:0]         resp_result,
    output logic                mult_enable,
    output logic [31:0]         mult_dataa,
    output logic [31:0]         mult_datab,
    input  logic [31:0]         mult_result,
    input  logic                mult_done,
    output logic                busy
);
    localparam int          IW      = $clog2(N_REQ);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    // watchdog holds (n-1) during the n-th RUN cycle
    localparam logic [7:0]  WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;

    state_t                  state;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           owner;
    logic [IW-1:0]           pick_idx;
    logic [IW-1:0]           cand;
    logic                    pick_vld;
    logic [7:0]              wdog;
    logic [N_REQ-1:0][31:0]  opa;
    logic [N_REQ-1:0][31:0]  opb;

    assign opa = req_dataa;
    assign opb = req_datab;

    // rotating priority: the first requester at or above rr_ptr wins;
    // scanning from the far end lets the nearest candidate overwrite last
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            cand = IW'((int'(rr_ptr) + j) % N_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // control FSM with registered handshake and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            wdog        <= '0;
            grant       <= '0;
            resp_valid  <= '0;
            resp_err    <= 1'b0;
            resp_result <= '0;
            mult_enable <= 1'b0;
            mult_dataa  <= '0;
            mult_datab  <= '0;
            busy        <= 1'b0;
        end else begin
            grant      <= '0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        mult_dataa  <= opa[pick_idx];
                        mult_datab  <= opb[pick_idx];
                        grant       <= N_REQ'(1) << pick_idx;
                        mult_enable <= 1'b1;
                        owner       <= pick_idx;
                        rr_ptr      <= IW'((int'(pick_idx) + 1) % N_REQ);
                        wdog        <= '0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    wdog <= wdog + 8'd1;
                    // a completion in the last allowed cycle still counts
                    if (mult_done) begin
                        resp_result <= mult_result;
                        resp_err    <= 1'b0;
                        resp_valid  <= N_REQ'(1) << owner;
                        mult_enable <= 1'b0;
                        state       <= RESP;
                    end else if (wdog == WD_LAST) begin
                        resp_result <= QNAN;
                        resp_err    <= 1'b1;
                        resp_valid  <= N_REQ'(1) << owner;
                        mult_enable <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    resp_err <= 1'b0;
                    state    <= GAP;
                end
                GAP: begin
                    // enable stays low one more cycle so the unit rearms
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_scheduler.sv
// Bench for fp_mult_scheduler: a latency-programmable multiplier model, a
// transaction-level scoreboard (round-robin choice, owner, product, error,
// latency), table vectors, corner sequences and randomized traffic.
module tb_fp_mult_scheduler;
    localparam int N  = 4;
    localparam int TO = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req;
    logic [N-1:0][31:0] da, db;
    logic [N-1:0]       grant, resp_valid;
    logic               resp_err, mult_enable, mult_done, busy;
    logic [31:0]        resp_result, mult_dataa, mult_datab, mult_result;

    fp_mult_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dataa(da), .req_datab(db),
        .grant(grant), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_result(resp_result), .mult_enable(mult_enable),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab),
        .mult_result(mult_result), .mult_done(mult_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rq;
        logic [31:0]  a, b;
        int           lat;
        logic [31:0]  mres, exp_res;
        logic         exp_err;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, en_cnt = 0, last_run = 0, cur_lat = 0, nresp = 0;
    int ptr_m = 0, owner_m = 0, gcyc = 0, rcyc = -100;
    logic        out_m = 1'b0;
    logic [31:0] cur_mres, cur_a, cur_b;
    logic [31:0] op_a [N], op_b [N], prod [N];
    int          lat_r [N];
    bit          auto_drop = 1'b1, spurious = 1'b0;
    int          gorder [$];
    int          exp_ord [5] = '{0, 1, 2, 3, 0};
    vec_t        tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired (cycle %0d)", nm, cyc);
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++)
            if (r[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input int l);
        op_a[i] = a; op_b[i] = b; prod[i] = p; lat_r[i] = l;
        da[i] = a;   db[i] = b;
    endtask

    // one clock: scoreboard the outputs, then drive the multiplier model
    task automatic tick();
        int  gi;
        bool_t: begin end
        @(posedge clk);
        #1;
        cyc++;
        chk("excl", 32'((|grant) && (|resp_valid)), 32'd0);
        if (|grant) begin
            gi = rr_pick(req, ptr_m);
            chk("grant", 32'(grant), (gi < 0) ? 32'd0 : 32'(1 << gi));
            chk("grant_busy", 32'(out_m), 32'd0);
            chk("grant_gap", 32'(cyc - rcyc >= 3), 32'd1);
            if (gi >= 0) begin
                chk("cap_a", mult_dataa, op_a[gi]);
                chk("cap_b", mult_datab, op_b[gi]);
                ptr_m = (gi + 1) % N; owner_m = gi; out_m = 1'b1; gcyc = cyc;
                cur_lat = lat_r[gi]; cur_mres = prod[gi];
                cur_a = op_a[gi]; cur_b = op_b[gi];
                gorder.push_back(gi);
                if (auto_drop) req[gi] = 1'b0;
            end
        end
        if (|resp_valid) begin
            chk("resp_owned", 32'(out_m), 32'd1);
            chk("resp_vec", 32'(resp_valid), 32'(1 << owner_m));
            chk("resp_res", resp_result, (cur_lat >= TO) ? 32'h7FC0_0000 : cur_mres);
            chk("resp_err", 32'(resp_err), 32'(cur_lat >= TO));
            chk("resp_lat", 32'(cyc - gcyc), (cur_lat >= TO) ? 32'(TO) : 32'(cur_lat + 1));
            out_m = 1'b0; rcyc = cyc; nresp++;
        end else begin
            chk("err_idle", 32'(resp_err), 32'd0);
        end
        if (out_m) begin
            chk("busy", 32'(busy), 32'd1);
            if (mult_enable) begin
                chk("run_a", mult_dataa, cur_a);
                chk("run_b", mult_datab, cur_b);
            end
        end
        if (mult_enable) en_cnt++;
        else begin
            if (en_cnt != 0) last_run = en_cnt;
            en_cnt = 0;
        end
        mult_done   = (mult_enable && en_cnt == cur_lat + 1) || spurious;
        mult_result = (mult_enable && en_cnt == cur_lat + 1) ? cur_mres : (32'hDEAD_0000 | 32'(cyc));
    endtask

    task automatic wait_resp(input int n0, input int budget);
        int k = 0;
        while (nresp == n0 && k < budget) begin tick(); k++; end
        if (nresp == n0) bound_fail("wait_resp");
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((req != '0 || out_m) && k < budget) begin tick(); k++; end
        if (req != '0 || out_m) bound_fail("drain");
        tick(); tick();
    endtask

    initial begin
        int k, n0, idx;
        reset = 1'b1; req = '0; da = '0; db = '0;
        mult_done = 1'b0; mult_result = '0;
        cur_mres = '0; cur_a = '0; cur_b = '0;
        for (int i = 0; i < N; i++) set_op(i, 32'd0, 32'd0, 32'd0, 1);

        tbl[0] = '{4'b0001, 32'h4000_0000, 32'h4040_0000, 3,      32'h40C0_0000, 32'h40C0_0000, 1'b0};
        tbl[1] = '{4'b0100, 32'h3F00_0000, 32'h4080_0000, 1,      32'h4000_0000, 32'h4000_0000, 1'b0};
        tbl[2] = '{4'b1000, 32'h4300_0000, 32'h3C00_0000, 6,      32'h3F80_0000, 32'h3F80_0000, 1'b0};
        tbl[3] = '{4'b0010, 32'h4040_0000, 32'h4040_0000, TO - 1, 32'h4110_0000, 32'h4110_0000, 1'b0};
        tbl[4] = '{4'b0010, 32'h4100_0000, 32'h4100_0000, 200,    32'h1234_5678, 32'h7FC0_0000, 1'b1};
        tbl[5] = '{4'b0001, 32'h3F80_0000, 32'h3F80_0000, TO,     32'h3F80_0000, 32'h7FC0_0000, 1'b1};

        // reset state
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_en", 32'(mult_enable), 32'd0);
        chk("rst_da", mult_dataa, 32'd0);
        chk("rst_db", mult_datab, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // fairness with every request held high
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++)
            set_op(i, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i), 32'h4100_0000 + 32'(i), 2);
        req = '1;
        k = 0;
        while (gorder.size() < 5 && k < 300) begin tick(); k++; end
        req = '0;
        if (gorder.size() < 5) bound_fail("rr_grants");
        else for (int j = 0; j < 5; j++) chk("rr_order", 32'(gorder[j]), 32'(exp_ord[j]));
        drain(300);
        auto_drop = 1'b1;

        // table vectors: single requests incl. timeout boundaries
        for (int v = 0; v < 6; v++) begin
            idx = $clog2(tbl[v].rq);
            set_op(idx, tbl[v].a, tbl[v].b, tbl[v].mres, tbl[v].lat);
            req = tbl[v].rq;
            n0 = nresp;
            tick();
            chk("tbl_grant", 32'(grant), 32'(tbl[v].rq));
            wait_resp(n0, 300);
            chk("tbl_vld", 32'(resp_valid), 32'(tbl[v].rq));
            chk("tbl_res", resp_result, tbl[v].exp_res);
            chk("tbl_err", 32'(resp_err), 32'(tbl[v].exp_err));
            chk("tbl_run", 32'(last_run), tbl[v].exp_err ? 32'(TO) : 32'(tbl[v].lat + 1));
            tick(); tick();
            chk("tbl_held", resp_result, tbl[v].exp_res);
        end

        // req[2] toggling during req[0]'s product, then spurious done in IDLE
        set_op(0, 32'h40A0_0000, 32'h4000_0000, 32'h4120_0000, 8);
        req = 4'b0001;
        n0 = nresp;
        tick();
        for (int t = 0; t < 4; t++) begin
            set_op(2, $urandom, $urandom, 32'd0, 1);
            req[2] = (t % 2 == 0);
            tick();
        end
        wait_resp(n0, 100);
        chk("t6_vld", 32'(resp_valid), 32'd1);
        chk("t6_res", resp_result, 32'h4120_0000);
        tick(); tick();
        n0 = nresp;
        spurious = 1'b1;
        repeat (4) tick();
        spurious = 1'b0;
        tick();
        chk("spur_noresp", 32'(nresp), 32'(n0));
        chk("spur_busy", 32'(busy), 32'd0);
        tick(); tick();

        // asynchronous reset in RUN
        set_op(1, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 30);
        req = 4'b0010;
        tick();
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_en", 32'(mult_enable), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_rvalid", 32'(resp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        out_m = 1'b0; ptr_m = 0;
        tick(); tick();
        reset = 1'b0;
        n0 = nresp;
        repeat (40) tick();
        chk("arst_noresp", 32'(nresp), 32'(n0));
        set_op(1, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2);
        set_op(3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 2);
        req = 4'b1010;
        tick();
        chk("arst_ptr", 32'(grant), 32'b0010);
        drain(300);

        // randomized traffic against the scoreboard
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    set_op(i, $urandom, $urandom, $urandom,
                           ($urandom_range(19) == 0) ? 70 : int'($urandom_range(6, 1)));
                    req[i] = 1'b1;
                end
            end
            tick();
        end
        drain(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
